// File: rtl/instr_fetch_mo_if.sv
// Fetch-unit bus bundle: predictor request, instruction-memory request/response, decoder output.
// Latency: none (wires only).
// Backpressure: carried by o_req_ready/i_mem_req_ready/i_ready; o_mem_resp_ready is always 1.
interface instr_fetch_mo_if #(
  parameter int XLEN    = 64,
  parameter int INSTR_W = 64
);
  logic               i_req_valid;
  logic [XLEN-1:0]    i_req_addr;
  logic               o_req_ready;
  logic               o_mem_req_valid;
  logic [XLEN-1:0]    o_mem_req_addr;
  logic               i_mem_req_ready;
  logic               i_mem_data_valid;
  logic [INSTR_W-1:0] i_mem_data;
  logic               i_mem_load_fault;
  logic               i_mem_page_fault_x;
  logic               o_mem_resp_ready;
  logic               i_flush;
  logic               o_valid;
  logic [XLEN-1:0]    o_pc;
  logic [INSTR_W-1:0] o_instr;
  logic               o_load_fault;
  logic               o_page_fault_x;
  logic               i_ready;

  // Fetch-unit side.
  modport slave (
    input  i_req_valid, i_req_addr, i_mem_req_ready, i_mem_data_valid, i_mem_data,
           i_mem_load_fault, i_mem_page_fault_x, i_flush, i_ready,
    output o_req_ready, o_mem_req_valid, o_mem_req_addr, o_mem_resp_ready,
           o_valid, o_pc, o_instr, o_load_fault, o_page_fault_x
  );

  // Environment side (predictor, memory, decoder).
  modport master (
    output i_req_valid, i_req_addr, i_mem_req_ready, i_mem_data_valid, i_mem_data,
           i_mem_load_fault, i_mem_page_fault_x, i_flush, i_ready,
    input  o_req_ready, o_mem_req_valid, o_mem_req_addr, o_mem_resp_ready,
           o_valid, o_pc, o_instr, o_load_fault, o_page_fault_x
  );
endinterface

// File: rtl/instr_fetch_mo.sv
// Multi-outstanding instruction fetch: issues predictor addresses to memory, queues in-order responses.
// Latency: memory response to o_valid is 1 cycle (no bypass); issue to o_valid is 2 with a 1-cycle memory.
// Backpressure: issue gated by credits (inflight + queued < DEPTH); responses always accepted.
module instr_fetch_mo #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 64
) (
  input logic               i_clk,
  input logic               i_rst,
  instr_fetch_mo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [CW-1:0] inflight, stale, qcount;
  logic [AW-1:0] a_wr, a_rd, q_wr, q_rd;

  logic [XLEN-1:0]    addr_mem [DEPTH];
  logic [XLEN-1:0]    q_pc     [DEPTH];
  logic [INSTR_W-1:0] q_instr  [DEPTH];
  logic               q_lf     [DEPTH];
  logic               q_pf     [DEPTH];

  logic credit_ok, issue, resp, resp_live, resp_drop, q_push, q_pop, head_vld, fault_in;

  // Credits count both outstanding requests and queued results, so a response always has a slot.
  assign credit_ok = ({1'b0, inflight} + {1'b0, qcount}) < DEPTH_C;

  assign bus.o_mem_req_valid  = bus.i_req_valid && credit_ok && !bus.i_flush && !i_rst;
  assign bus.o_req_ready      = bus.i_mem_req_ready && credit_ok && !bus.i_flush && !i_rst;
  assign bus.o_mem_req_addr   = bus.i_req_addr;
  assign bus.o_mem_resp_ready = 1'b1;

  assign issue     = bus.o_mem_req_valid && bus.i_mem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp      = bus.i_mem_data_valid && (inflight != '0);
  assign resp_live = resp && (stale == '0);
  assign resp_drop = resp && (stale != '0);
  // A live response landing in the flush cycle belongs to the discarded stream.
  assign q_push    = resp_live && !bus.i_flush;
  assign head_vld  = (qcount != '0);
  assign q_pop     = head_vld && bus.i_ready;
  assign fault_in  = bus.i_mem_load_fault || bus.i_mem_page_fault_x;

  assign bus.o_valid        = head_vld;
  assign bus.o_pc           = head_vld ? q_pc[q_rd] : '1;
  assign bus.o_instr        = head_vld ? q_instr[q_rd] : '0;
  assign bus.o_load_fault   = head_vld && q_lf[q_rd];
  assign bus.o_page_fault_x = head_vld && q_pf[q_rd];

  // Counters and pointers; flush clears the queues but keeps tracking responses still owed by memory.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
      stale    <= '0;
      qcount   <= '0;
      a_wr     <= '0;
      a_rd     <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(resp);
      if (bus.i_flush) begin
        stale  <= inflight - CW'(resp);
        a_wr   <= '0;
        a_rd   <= '0;
        q_wr   <= '0;
        q_rd   <= '0;
        qcount <= '0;
      end else begin
        if (resp_drop) stale <= stale - CW'(1);
        if (issue)     a_wr  <= a_wr + AW'(1);
        if (resp_live) a_rd  <= a_rd + AW'(1);
        if (q_push)    q_wr  <= q_wr + AW'(1);
        if (q_pop)     q_rd  <= q_rd + AW'(1);
        qcount <= qcount + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  // Storage: address FIFO written on issue, result queue written on live response (faulted data zeroed).
  always_ff @(posedge i_clk) begin
    if (issue) addr_mem[a_wr] <= bus.i_req_addr;
    if (q_push) begin
      q_pc[q_wr]    <= addr_mem[a_rd];
      q_instr[q_wr] <= fault_in ? '0 : bus.i_mem_data;
      q_lf[q_wr]    <= bus.i_mem_load_fault;
      q_pf[q_wr]    <= bus.i_mem_page_fault_x;
    end
  end
endmodule

// File: tb/tb_instr_fetch_mo.sv
// Directed bench for instr_fetch_mo with a 1-cycle in-order memory model and a scoreboard monitor.
// Latency: expects o_valid two cycles after issue when the decoder keeps up.
// Backpressure: exercises credit stall, flush, reset and fault propagation.
module tb_instr_fetch_mo;
  typedef struct {
    logic [63:0] pc;
    logic [63:0] instr;
    logic        lf;
    logic        pf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cnt = 0;
  bit   mem_en = 0;
  bit   chk_lat = 0;
  exp_t sb_q[$];
  logic [63:0] mem_q[$];

  instr_fetch_mo_if #(.XLEN(64), .INSTR_W(64)) bus ();

  instr_fetch_mo #(.XLEN(64), .DEPTH(4), .INSTR_W(64)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mdata(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic is_pf(input logic [63:0] a);
    return a == 64'h3000;
  endfunction

  function automatic logic is_lf(input logic [63:0] a);
    return a == 64'h4000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: compare decoder pops against the scoreboard, then record new issues.
  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_o_valid", 64'(bus.o_valid), 64'd0);
      end else if (bus.i_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("o_pc", bus.o_pc, e.pc);
        chk("o_instr", bus.o_instr, e.instr);
        chk("o_load_fault", 64'(bus.o_load_fault), 64'(e.lf));
        chk("o_page_fault_x", 64'(bus.o_page_fault_x), 64'(e.pf));
        if (chk_lat) chk("issue_to_valid_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    if (bus.i_flush || rst) sb_q.delete();
    if (bus.o_mem_req_valid && bus.i_mem_req_ready) begin
      exp_t n;
      n.pc    = bus.o_mem_req_addr;
      n.lf    = is_lf(bus.o_mem_req_addr);
      n.pf    = is_pf(bus.o_mem_req_addr);
      n.instr = (n.lf || n.pf) ? 64'd0 : mdata(bus.o_mem_req_addr);
      n.cyc   = cyc;
      sb_q.push_back(n);
      mem_q.push_back(bus.o_mem_req_addr);
      issue_cnt++;
    end
  end

  // Memory model: returns the oldest accepted request one cycle later, in order.
  initial begin
    bus.i_mem_data_valid   = 0;
    bus.i_mem_data         = '0;
    bus.i_mem_load_fault   = 0;
    bus.i_mem_page_fault_x = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_en && mem_q.size() > 0) begin
        logic [63:0] a;
        a = mem_q.pop_front();
        bus.i_mem_data_valid   = 1;
        bus.i_mem_data         = mdata(a);
        bus.i_mem_load_fault   = is_lf(a);
        bus.i_mem_page_fault_x = is_pf(a);
      end else begin
        bus.i_mem_data_valid   = 0;
        bus.i_mem_data         = '0;
        bus.i_mem_load_fault   = 0;
        bus.i_mem_page_fault_x = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a);
    int n;
    n = 0;
    bus.i_req_valid = 1;
    bus.i_req_addr  = a;
    @(negedge clk);
    while (!(bus.o_mem_req_valid && bus.i_mem_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
    step(1);
    bus.i_req_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    step(2);
  endtask

  initial begin
    int k;
    rst = 1;
    bus.i_req_valid     = 1;
    bus.i_req_addr      = 64'h55;
    bus.i_mem_req_ready = 1;
    bus.i_flush         = 0;
    bus.i_ready         = 1;
    step(3);
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_pc", bus.o_pc, '1);
    chk("rst_o_instr", bus.o_instr, 64'd0);
    chk("rst_o_mem_req_valid", 64'(bus.o_mem_req_valid), 64'd0);
    chk("rst_o_req_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_faults", 64'({bus.o_load_fault, bus.o_page_fault_x}), 64'd0);
    chk("o_mem_resp_ready", 64'(bus.o_mem_resp_ready), 64'd1);
    chk("rst_inflight", 64'(dut.inflight), 64'd0);
    rst = 0;
    bus.i_req_valid = 0;
    mem_en = 1;
    step(1);
    chk("idle_o_req_ready", 64'(bus.o_req_ready), 64'd1);

    // In-order stream with fixed latency.
    chk_lat = 1;
    send(64'h1000);
    send(64'h1008);
    send(64'h1010);
    drain();
    // Faults per entry, not sticky.
    send(64'h3000);
    send(64'h3008);
    send(64'h4000);
    send(64'h4008);
    drain();
    chk_lat = 0;

    // Credit limit with a stalled decoder.
    bus.i_ready = 0;
    k = 0;
    bus.i_req_valid = 1;
    bus.i_req_addr  = 64'h700;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.o_mem_req_valid && bus.i_mem_req_ready) k++;
      step(1);
      bus.i_req_addr = 64'h700 + 64'(8 * k);
      if (k == 6) bus.i_req_valid = 0;
    end
    bus.i_req_valid = 0;
    chk("credit_issued", 64'(k), 64'd4);
    chk("credit_o_req_ready", 64'(bus.o_req_ready), 64'd0);
    chk("credit_qcount", 64'(dut.qcount), 64'd4);
    bus.i_ready = 1;
    step(1);
    bus.i_ready = 0;
    chk("credit_reopen", 64'(bus.o_req_ready), 64'd1);
    bus.i_ready = 1;
    drain();

    // Flush with three in flight; stale responses dropped, new stream starts at 0x2000.
    mem_en = 0;
    send(64'h100);
    send(64'h108);
    send(64'h110);
    chk("flush_inflight", 64'(dut.inflight), 64'd3);
    bus.i_flush = 1;
    step(1);
    bus.i_flush = 0;
    chk("flush_stale", 64'(dut.stale), 64'd3);
    chk("flush_qcount", 64'(dut.qcount), 64'd0);
    mem_en = 1;
    send(64'h2000);
    drain();
    chk("flush_stale_done", 64'(dut.stale), 64'd0);
    chk("flush_inflight_done", 64'(dut.inflight), 64'd0);

    // Flush coincident with a response.
    mem_en = 0;
    send(64'h500);
    send(64'h508);
    send(64'h510);
    bus.i_flush = 1;
    mem_en = 1;
    step(1);
    bus.i_flush = 0;
    chk("flush_resp_stale", 64'(dut.stale), 64'd2);
    step(5);
    chk("flush_resp_stale_done", 64'(dut.stale), 64'd0);
    chk("flush_resp_inflight", 64'(dut.inflight), 64'd0);
    chk("flush_resp_o_valid", 64'(bus.o_valid), 64'd0);

    // Reset with two queued and two in flight.
    bus.i_ready = 0;
    send(64'h600);
    send(64'h608);
    step(3);
    mem_en = 0;
    send(64'h610);
    send(64'h618);
    chk("pre_rst_qcount", 64'(dut.qcount), 64'd2);
    chk("pre_rst_inflight", 64'(dut.inflight), 64'd2);
    rst = 1;
    bus.i_req_valid = 1;
    bus.i_req_addr  = 64'h800;
    step(1);
    chk("mid_rst_o_mem_req_valid", 64'(bus.o_mem_req_valid), 64'd0);
    chk("mid_rst_o_req_ready", 64'(bus.o_req_ready), 64'd0);
    rst = 0;
    bus.i_req_valid = 0;
    #1;
    chk("post_rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("post_rst_o_pc", bus.o_pc, '1);
    chk("post_rst_o_req_ready", 64'(bus.o_req_ready), 64'd1);
    // Pre-reset responses now arrive with nothing outstanding and must be ignored.
    mem_en = 1;
    bus.i_ready = 1;
    step(6);
    chk("post_rst_inflight", 64'(dut.inflight), 64'd0);
    chk("post_rst_qcount", 64'(dut.qcount), 64'd0);
    chk("post_rst_o_valid_late", 64'(bus.o_valid), 64'd0);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_mo.md
INSTR_FETCH_MO -- requirements
Module: instr_fetch_mo

Interface
REQ-001 Parameter XLEN, default 64, address/PC width in bits.
REQ-002 Parameter DEPTH, default 4, max outstanding fetches and output-queue depth; power of two, 2..8.
REQ-003 Parameter INSTR_W, default 64, fetched instruction word width.
REQ-004 Port i_clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port i_rst  in  1  reset, synchronous and active-high.
REQ-006 Port i_req_valid  in  1  predictor presents a fetch address.
REQ-007 Port i_req_addr  in  XLEN  fetch address from predictor.
REQ-008 Port o_req_ready  out  1  fetch address accepted this cycle.
REQ-009 Port o_mem_req_valid  out  1  request to instruction memory.
REQ-010 Port o_mem_req_addr  out  XLEN  memory request address.
REQ-011 Port i_mem_req_ready  in  1  memory accepts request.
REQ-012 Port i_mem_data_valid  in  1  memory response valid; responses return in request order.
REQ-013 Port i_mem_data  in  INSTR_W  response data.
REQ-014 Port i_mem_load_fault  in  1  access fault on this response.
REQ-015 Port i_mem_page_fault_x  in  1  execute page fault on this response.
REQ-016 Port o_mem_resp_ready  out  1  fetch can take a response; tied 1 (credit scheme guarantees space).
REQ-017 Port i_flush  in  1  pipeline redirect: discard all in-flight and queued fetches.
REQ-018 Port o_valid  out  1  head of output queue valid to decoder.
REQ-019 Port o_pc  out  XLEN  PC of head entry.
REQ-020 Port o_instr  out  INSTR_W  instruction of head entry.
REQ-021 Port o_load_fault  out  1  head entry access fault.
REQ-022 Port o_page_fault_x  out  1  head entry page fault.
REQ-023 Port i_ready  in  1  decoder consumes head entry when o_valid && i_ready.

Function
REQ-024 Issue handshake: credit_ok = (inflight + qcount) < DEPTH; o_mem_req_valid = i_req_valid && credit_ok && !i_flush; o_req_ready = i_mem_req_ready && credit_ok && !i_flush; o_mem_req_addr = i_req_addr (combinational).
REQ-025 Issue fires on o_mem_req_valid && i_mem_req_ready; address pushed into DEPTH-entry address FIFO; inflight increments.
REQ-026 Response with stale == 0: pop address FIFO, push {addr, data, faults} into output queue; inflight decrements; o_valid asserts next cycle (1-cycle latency, no bypass).
REQ-027 Response with stale > 0: data dropped, stale decrements, inflight decrements; address FIFO not touched (already cleared on flush).
REQ-028 Flush: output queue and address FIFO emptied; stale <= inflight minus any response arriving same cycle; no issue in flush cycle; inflight still tracks outstanding responses.
REQ-029 Simultaneous issue and response same cycle: inflight unchanged; FIFO push and pop both occur.
REQ-030 Simultaneous push and decoder pop on output queue: qcount unchanged; full queue with pop allows push.
REQ-031 Counters inflight, stale, qcount are clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH; inflight+qcount never exceeds DEPTH.
REQ-032 Faults carried per entry, never sticky; o_instr forced 0 when either fault bit set.
REQ-033 Response when inflight == 0 is a protocol error: ignored, counters unchanged.

Reset
REQ-034 On i_rst: inflight, stale, qcount, pointers = 0; o_valid = 0, o_mem_req_valid = 0, o_req_ready = 0, o_pc = all ones, o_instr = 0, faults = 0.
REQ-035 Reset mid-operation drops all outstanding state; responses for pre-reset requests arriving after reset fall under REQ-033.

Verification
REQ-036 Stream: DEPTH=4, mem ready always, 1-cycle response, decoder ready -> addrs 0x1000,0x1008,0x1010 appear on o_pc in order, 2 cycles after issue each.
REQ-037 Credit: decoder i_ready=0, 6 requests offered -> exactly 4 issued, o_req_ready=0 thereafter until a pop.
REQ-038 Flush with 3 in flight -> stale=3, next 3 responses dropped, new addr 0x2000 issued later appears as first o_pc.
REQ-039 Flush cycle coincident with response -> stale=2 for 3 in flight, no stale entry leaks to o_valid.
REQ-040 Response with i_mem_page_fault_x=1 at 0x3000 -> o_page_fault_x=1, o_instr=0, o_pc=0x3000; next entry faults clear.
REQ-041 i_rst asserted with 2 in flight and 2 queued -> next cycle o_valid=0, o_pc=all ones, o_req_ready follows REQ-024 with counters zero.
